// File: rtl/uart_frame_ice40_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types and constants for the uart_frame_ice40 slice:
//             receiver FSM state encodings and parity-mode constants.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Parity modes (value of the PARITY parameter)
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Number of bitxce strobes per bit period
  function automatic int sub_ratio(input int subdiv16);
    return (subdiv16 != 0) ? 16 : 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_ice40_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_ice40_if
//  Purpose  : Host-side bundle of the UART: baud strobe, transmit request,
//             serial pins and receive status.
//  Ports    : master - host/board side (drives bitxce, load, d, rxpin)
//             slave  - UART core side (drives txpin, txbusy, bytercvd,
//                      parerr, frameerr, q)
//  Revision : 1.0  initial release
// ============================================================================
interface uart_frame_ice40_if #(
  parameter int DATABITS = 8
);
  logic                bitxce;
  logic                load;
  logic [DATABITS-1:0] d;
  logic                rxpin;
  logic                txpin;
  logic                txbusy;
  logic                bytercvd;
  logic                parerr;
  logic                frameerr;
  logic [DATABITS-1:0] q;

  modport master (
    output bitxce, load, d, rxpin,
    input  txpin, txbusy, bytercvd, parerr, frameerr, q
  );

  modport slave (
    input  bitxce, load, d, rxpin,
    output txpin, txbusy, bytercvd, parerr, frameerr, q
  );
endinterface
`default_nettype wire

// File: rtl/uart_frame_ice40_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_rx
//  Purpose  : UART receiver: start-edge hunt, mid-bit sampling, parity
//             check, stop-bit check and break recovery.
//  Ports    : clk, rst        clock, async active-high reset
//             bitxce_i        oversampling strobe (8 or 16 per bit)
//             rxpin_i         serial line, idle high
//             bytercvd_o      1-cycle pulse, frame with valid stop bit
//             parerr_o        1-cycle pulse with bytercvd_o on parity fail
//             frameerr_o      1-cycle pulse, stop bit sampled low
//             q_o             last received data
//  Revision : 1.0  initial release
// ============================================================================
module uart_frame_rx
  import uart_pkg::*;
#(
  parameter int DATABITS = 8,
  parameter int PARITY   = 0,
  parameter int SUBDIV16 = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bitxce_i,
  input  logic                rxpin_i,
  output logic                bytercvd_o,
  output logic                parerr_o,
  output logic                frameerr_o,
  output logic [DATABITS-1:0] q_o
);
  localparam int         N         = sub_ratio(SUBDIV16);
  localparam logic [3:0] DIV_LAST  = 4'(N - 1);
  localparam logic [3:0] DIV_HALF  = 4'(N / 2);
  localparam logic [3:0] BIT_LAST  = 4'(DATABITS - 1);
  localparam logic       ODD_SENSE = (PARITY == PAR_ODD);

  rx_state_e           state_q, state_d;
  logic                rxs_q;
  logic [3:0]          div_q, div_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATABITS-1:0] sh_q, sh_d;
  logic [DATABITS-1:0] q_q, q_d;
  logic                par_q, par_d;
  logic                perr_q, perr_d;
  logic                rcvd_q, rcvd_d;
  logic                perrp_q, perrp_d;
  logic                ferr_q, ferr_d;
  logic                mid_sample;

  // Divider wraps at the mid-bit point because HUNT parks it at N/2.
  assign mid_sample = bitxce_i && (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HUNT;
      rxs_q   <= 1'b1;
      div_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      q_q     <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      rcvd_q  <= 1'b0;
      perrp_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rxs_q   <= rxpin_i;   // single register: one clk detection latency
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      rcvd_q  <= rcvd_d;
      perrp_q <= perrp_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    q_d     = q_q;
    par_d   = par_q;
    perr_d  = perr_q;
    rcvd_d  = 1'b0;
    perrp_d = 1'b0;
    ferr_d  = 1'b0;

    if (bitxce_i) begin
      div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    end

    unique case (state_q)
      ST_HUNT: begin
        div_d = DIV_HALF;
        if (!rxs_q) state_d = ST_START;
      end
      ST_START: begin
        if (mid_sample) begin
          if (rxs_q) begin
            state_d = ST_HUNT;            // glitch, not a start bit
          end else begin
            state_d = ST_DATA;
            cnt_d   = '0;
            par_d   = 1'b0;
            perr_d  = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (mid_sample) begin
          sh_d  = {rxs_q, sh_q[DATABITS-1:1]};
          par_d = par_q ^ rxs_q;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == BIT_LAST) begin
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (mid_sample) begin
          // Ones count of data plus parity bit must be even (or odd).
          perr_d  = par_q ^ rxs_q ^ ODD_SENSE;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (mid_sample) begin
          if (rxs_q) begin
            q_d     = sh_q;
            rcvd_d  = 1'b1;
            perrp_d = perr_q;
            state_d = ST_HUNT;            // re-arm at mid-stop for back-to-back
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxs_q) state_d = ST_HUNT;
      end
      default: state_d = ST_HUNT;
    endcase
  end

  assign bytercvd_o = rcvd_q;
  assign parerr_o   = perrp_q;
  assign frameerr_o = ferr_q;
  assign q_o        = q_q;

endmodule
`default_nettype wire

// File: rtl/uart_frame_ice40.sv
`default_nettype none
// ============================================================================
//  Module   : uart_frame_ice40
//  Purpose  : Full-duplex parametrised UART (5..9 data bits, none/even/odd
//             parity, 1 or 2 stop bits, 8x or 16x oversampling).
//  Ports    : clk, rst   clock, async active-high reset
//             bus        uart_frame_ice40_if.slave: bitxce, load, d, rxpin
//                        in; txpin (inverted line), txbusy, bytercvd,
//                        parerr, frameerr, q out
//  Revision : 1.0  initial release
// ============================================================================
module uart_frame_ice40
  import uart_pkg::*;
#(
  parameter int DATABITS = 8,
  parameter int PARITY   = 0,
  parameter int STOPBITS = 1,
  parameter int SUBDIV16 = 0
) (
  input  logic              clk,
  input  logic              rst,
  uart_frame_ice40_if.slave bus
);
  if (DATABITS < 5 || DATABITS > 9) begin : g_bad_databits
    $error("uart_frame_ice40: DATABITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
    $error("uart_frame_ice40: PARITY must be 0, 1 or 2");
  end
  if (STOPBITS < 1 || STOPBITS > 2) begin : g_bad_stopbits
    $error("uart_frame_ice40: STOPBITS must be 1 or 2");
  end
  if (SUBDIV16 < 0 || SUBDIV16 > 1) begin : g_bad_subdiv
    $error("uart_frame_ice40: SUBDIV16 must be 0 or 1");
  end

  localparam int         N         = sub_ratio(SUBDIV16);
  localparam logic [3:0] DIV_LAST  = 4'(N - 1);
  localparam int         PBITS     = (PARITY != PAR_NONE) ? 1 : 0;
  localparam int         FRAMELEN  = 1 + DATABITS + PBITS + STOPBITS;
  localparam logic [3:0] FRAME_CNT = 4'(FRAMELEN);

  logic [3:0]          txdiv_q, txdiv_d;
  logic [FRAMELEN-1:0] txsh_q, txsh_d;
  logic [3:0]          txrem_q, txrem_d;
  logic                txbusy_q, txbusy_d;
  logic                txpin_q, txpin_d;
  logic [FRAMELEN-1:0] frame;
  logic                txce;

  assign txce = bus.bitxce && (txdiv_q == DIV_LAST);

  // Frame in transmit order from bit 0: start, data LSB first, parity, stops.
  always_comb begin
    frame              = '1;
    frame[0]           = 1'b0;
    frame[DATABITS:1]  = bus.d;
    if (PARITY != PAR_NONE) begin
      frame[DATABITS+1] = (^bus.d) ^ (PARITY == PAR_ODD);
    end
  end

  always_comb begin
    txdiv_d  = txdiv_q;
    txsh_d   = txsh_q;
    txrem_d  = txrem_q;
    txbusy_d = txbusy_q;
    txpin_d  = txpin_q;

    if (bus.bitxce) begin
      txdiv_d = (txdiv_q == DIV_LAST) ? 4'd0 : txdiv_q + 4'd1;
    end

    if (!txbusy_q) begin
      if (bus.load) begin
        txsh_d   = frame;
        txrem_d  = FRAME_CNT;
        txbusy_d = 1'b1;
      end
    end else if (txce) begin
      if (txrem_q != 4'd0) begin
        txpin_d = ~txsh_q[0];         // pin carries the inverted line level
        txsh_d  = txsh_q >> 1;
        txrem_d = txrem_q - 4'd1;
      end else begin
        // This txce closes the last stop bit.
        txbusy_d = 1'b0;
        txpin_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txdiv_q  <= '0;
      txsh_q   <= '0;
      txrem_q  <= '0;
      txbusy_q <= 1'b0;
      txpin_q  <= 1'b0;
    end else begin
      txdiv_q  <= txdiv_d;
      txsh_q   <= txsh_d;
      txrem_q  <= txrem_d;
      txbusy_q <= txbusy_d;
      txpin_q  <= txpin_d;
    end
  end

  assign bus.txpin  = txpin_q;
  assign bus.txbusy = txbusy_q;

  uart_frame_rx #(
    .DATABITS (DATABITS),
    .PARITY   (PARITY),
    .SUBDIV16 (SUBDIV16)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .bitxce_i   (bus.bitxce),
    .rxpin_i    (bus.rxpin),
    .bytercvd_o (bus.bytercvd),
    .parerr_o   (bus.parerr),
    .frameerr_o (bus.frameerr),
    .q_o        (bus.q)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ice40.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_frame_ice40
//  Purpose  : Directed self-checking bench for uart_frame_ice40.
//             dut_a: 8N1, 8x   (tx frame, glitch, framing error)
//             dut_b: 7E2, 16x  (tx->rx loopback, reset mid-frame)
//             dut_c: 8O1, 8x   (parity check)
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_frame_ice40;
  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic bitxce = 1'b0;

  int checks = 0;
  int errors = 0;

  // pulse counters per DUT (index 0=a, 1=b, 2=c)
  int rcvd_n [3] = '{0, 0, 0};
  int perr_n [3] = '{0, 0, 0};
  int ferr_n [3] = '{0, 0, 0};
  int co_n   [3] = '{0, 0, 0};

  uart_frame_ice40_if #(.DATABITS(8)) ifa ();
  uart_frame_ice40_if #(.DATABITS(7)) ifb ();
  uart_frame_ice40_if #(.DATABITS(8)) ifc ();

  assign ifa.bitxce = bitxce;
  assign ifb.bitxce = bitxce;
  assign ifc.bitxce = bitxce;
  assign ifb.rxpin  = ~ifb.txpin;   // loopback through the inverted pin

  uart_frame_ice40 #(.DATABITS(8), .PARITY(0), .STOPBITS(1), .SUBDIV16(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  uart_frame_ice40 #(.DATABITS(7), .PARITY(1), .STOPBITS(2), .SUBDIV16(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  uart_frame_ice40 #(.DATABITS(8), .PARITY(2), .STOPBITS(1), .SUBDIV16(0))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  // bitxce: one cycle in four -> 8x bit = 32 clk, 16x bit = 64 clk
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      bitxce = 1'b1;
      @(negedge clk);
      bitxce = 1'b0;
    end
  end

  // pulse monitor, sampled 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ifa.bytercvd) rcvd_n[0]++;
      if (ifa.parerr)   perr_n[0]++;
      if (ifa.frameerr) ferr_n[0]++;
      if (ifa.parerr && ifa.bytercvd) co_n[0]++;
      if (ifb.bytercvd) rcvd_n[1]++;
      if (ifb.parerr)   perr_n[1]++;
      if (ifb.frameerr) ferr_n[1]++;
      if (ifb.parerr && ifb.bytercvd) co_n[1]++;
      if (ifc.bytercvd) rcvd_n[2]++;
      if (ifc.parerr)   perr_n[2]++;
      if (ifc.frameerr) ferr_n[2]++;
      if (ifc.parerr && ifc.bytercvd) co_n[2]++;
    end
  end

  // drive a bit sequence (bit 0 first) on dut_a (sel 0) or dut_c rxpin, 32 clk per bit
  task automatic send_bits(input int sel, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (sel == 0) ifa.rxpin = bits[i];
      else          ifc.rxpin = bits[i];
      repeat (32) @(negedge clk);
    end
    if (sel == 0) ifa.rxpin = 1'b1;
    else          ifc.rxpin = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.txpin, ifa.txbusy, ifa.bytercvd, ifa.parerr, ifa.frameerr, ifa.q} !== 13'h0) begin
      errors++; $display("FAIL reset_a: got %h want 0", {ifa.txpin, ifa.txbusy, ifa.bytercvd, ifa.parerr, ifa.frameerr, ifa.q});
    end
    checks++;
    if ({ifb.txpin, ifb.txbusy, ifb.bytercvd, ifb.parerr, ifb.frameerr, ifb.q} !== 12'h0) begin
      errors++; $display("FAIL reset_b: got %h want 0", {ifb.txpin, ifb.txbusy, ifb.bytercvd, ifb.parerr, ifb.frameerr, ifb.q});
    end
    checks++;
    if ({ifc.txpin, ifc.txbusy, ifc.bytercvd, ifc.parerr, ifc.frameerr, ifc.q} !== 13'h0) begin
      errors++; $display("FAIL reset_c: got %h want 0", {ifc.txpin, ifc.txbusy, ifc.bytercvd, ifc.parerr, ifc.frameerr, ifc.q});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_tx_frame();
    logic [9:0] exp_line;
    int n;
    int idx;
    exp_line = {1'b1, 8'hA5, 1'b0};   // stop, data, start (start sent first)
    ifa.d    = 8'hA5;
    ifa.load = 1'b1;
    @(negedge clk);
    ifa.load = 1'b0;
    ifa.d    = 8'h00;
    checks++;
    if (ifa.txbusy !== 1'b1) begin
      errors++; $display("FAIL tx_busy_rise: got %b want 1", ifa.txbusy);
    end
    n = 0;
    while (ifa.txpin !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n < 1 || n > 32) begin
      errors++; $display("FAIL tx_start_latency: got %0d clk want 1..32", n);
    end
    n = 0;
    while (ifa.txbusy === 1'b1 && n < 1000) begin
      if ((n % 32) == 16) begin
        idx = n / 32;
        if (idx < 10) begin
          checks++;
          if (~ifa.txpin !== exp_line[idx]) begin
            errors++; $display("FAIL tx_bit%0d: got line %b want %b", idx, ~ifa.txpin, exp_line[idx]);
          end
        end
      end
      if (n == 100) begin ifa.d = 8'h00; ifa.load = 1'b1; end   // ignored while busy
      if (n == 101) ifa.load = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 320) begin
      errors++; $display("FAIL tx_busy_len: got %0d clk want 320", n);
    end
    checks++;
    if (ifa.txpin !== 1'b0) begin
      errors++; $display("FAIL tx_idle: got %b want 0", ifa.txpin);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (ifa.txbusy !== 1'b0) begin
      errors++; $display("FAIL tx_no_reload: got txbusy %b want 0", ifa.txbusy);
    end
  endtask

  task automatic test_loopback();
    int r, p, f, n;
    r = rcvd_n[1]; p = perr_n[1]; f = ferr_n[1];
    ifb.d    = 7'h55;
    ifb.load = 1'b1;
    @(negedge clk);
    ifb.load = 1'b0;
    n = 0;
    while (rcvd_n[1] == r && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2000) begin
      errors++; $display("FAIL lb_timeout: got no bytercvd want 1");
    end
    checks++;
    if (ifb.q !== 7'h55) begin
      errors++; $display("FAIL lb_q: got %h want 55", ifb.q);
    end
    n = 0;
    while (ifb.txbusy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    repeat (100) @(negedge clk);
    checks++;
    if (rcvd_n[1] - r !== 1) begin
      errors++; $display("FAIL lb_rcvd_cycles: got %0d want 1", rcvd_n[1] - r);
    end
    checks++;
    if ((perr_n[1] - p) !== 0 || (ferr_n[1] - f) !== 0) begin
      errors++; $display("FAIL lb_errs: got par %0d frame %0d want 0 0", perr_n[1] - p, ferr_n[1] - f);
    end
  endtask

  task automatic test_glitch();
    int r, p, f;
    r = rcvd_n[0]; p = perr_n[0]; f = ferr_n[0];
    ifa.rxpin = 1'b0;
    repeat (6) @(negedge clk);
    ifa.rxpin = 1'b1;
    repeat (64) @(negedge clk);
    checks++;
    if ((rcvd_n[0] - r) !== 0 || (perr_n[0] - p) !== 0 || (ferr_n[0] - f) !== 0) begin
      errors++; $display("FAIL glitch_pulses: got %0d %0d %0d want 0 0 0", rcvd_n[0] - r, perr_n[0] - p, ferr_n[0] - f);
    end
    send_bits(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
    repeat (16) @(negedge clk);
    checks++;
    if (rcvd_n[0] - r !== 1) begin
      errors++; $display("FAIL glitch_recover_cnt: got %0d want 1", rcvd_n[0] - r);
    end
    checks++;
    if (ifa.q !== 8'h5A) begin
      errors++; $display("FAIL glitch_recover_q: got %h want 5a", ifa.q);
    end
  endtask

  task automatic test_framing();
    int r, f;
    r = rcvd_n[0]; f = ferr_n[0];
    // start, 0x0F, stop low, then line held low for three more bit periods
    send_bits(0, {3'b000, 3'b000, 1'b0, 8'h0F, 1'b0}, 13);
    repeat (64) @(negedge clk);
    checks++;
    if (ferr_n[0] - f !== 1) begin
      errors++; $display("FAIL frm_ferr_cnt: got %0d want 1", ferr_n[0] - f);
    end
    checks++;
    if (rcvd_n[0] - r !== 0) begin
      errors++; $display("FAIL frm_no_rcvd: got %0d want 0", rcvd_n[0] - r);
    end
    checks++;
    if (ifa.q !== 8'h5A) begin
      errors++; $display("FAIL frm_q_hold: got %h want 5a", ifa.q);
    end
    r = rcvd_n[0]; f = ferr_n[0];
    send_bits(0, {6'b0, 1'b1, 8'h96, 1'b0}, 10);
    repeat (16) @(negedge clk);
    checks++;
    if (rcvd_n[0] - r !== 1 || ferr_n[0] - f !== 0) begin
      errors++; $display("FAIL frm_next_cnt: got rcvd %0d ferr %0d want 1 0", rcvd_n[0] - r, ferr_n[0] - f);
    end
    checks++;
    if (ifa.q !== 8'h96) begin
      errors++; $display("FAIL frm_next_q: got %h want 96", ifa.q);
    end
  endtask

  task automatic test_parity();
    int r, p, c;
    r = rcvd_n[2]; p = perr_n[2]; c = co_n[2];
    // 0x81 has two ones: odd parity bit is 1
    send_bits(2, {5'b0, 1'b1, 1'b1, 8'h81, 1'b0}, 11);
    repeat (16) @(negedge clk);
    checks++;
    if (rcvd_n[2] - r !== 1 || perr_n[2] - p !== 0) begin
      errors++; $display("FAIL par_ok_cnt: got rcvd %0d par %0d want 1 0", rcvd_n[2] - r, perr_n[2] - p);
    end
    checks++;
    if (ifc.q !== 8'h81) begin
      errors++; $display("FAIL par_ok_q: got %h want 81", ifc.q);
    end
    r = rcvd_n[2]; p = perr_n[2];
    // 0x3C has four ones: correct odd parity bit is 1, send 0
    send_bits(2, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11);
    repeat (16) @(negedge clk);
    checks++;
    if (rcvd_n[2] - r !== 1 || perr_n[2] - p !== 1 || co_n[2] - c !== 1) begin
      errors++; $display("FAIL par_bad_cnt: got rcvd %0d par %0d same-cycle %0d want 1 1 1", rcvd_n[2] - r, perr_n[2] - p, co_n[2] - c);
    end
    checks++;
    if (ifc.q !== 8'h3C) begin
      errors++; $display("FAIL par_bad_q: got %h want 3c", ifc.q);
    end
  endtask

  task automatic test_reset_midframe();
    int n, ra, rb, rc, fa, fb, fc;
    ifb.d    = 7'h2B;
    ifb.load = 1'b1;
    @(negedge clk);
    ifb.load = 1'b0;
    n = 0;
    while (ifb.txpin !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (n >= 200) begin
      errors++; $display("FAIL rst_start_timeout: got no start bit want start");
    end
    repeat (224) @(negedge clk);    // middle of data bit 2
    checks++;
    if (ifb.txbusy !== 1'b1 || ifb.q !== 7'h55) begin
      errors++; $display("FAIL rst_pre: got busy %b q %h want 1 55", ifb.txbusy, ifb.q);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ifb.txpin, ifb.txbusy, ifb.bytercvd, ifb.parerr, ifb.frameerr, ifb.q} !== 12'h0) begin
      errors++; $display("FAIL rst_now_b: got %h want 0", {ifb.txpin, ifb.txbusy, ifb.bytercvd, ifb.parerr, ifb.frameerr, ifb.q});
    end
    checks++;
    if (ifa.q !== 8'h00 || ifc.q !== 8'h00) begin
      errors++; $display("FAIL rst_now_q: got a %h c %h want 0 0", ifa.q, ifc.q);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ra = rcvd_n[0]; rb = rcvd_n[1]; rc = rcvd_n[2];
    fa = ferr_n[0]; fb = ferr_n[1]; fc = ferr_n[2];
    repeat (192) @(negedge clk);
    checks++;
    if ((rcvd_n[0] - ra) + (rcvd_n[1] - rb) + (rcvd_n[2] - rc) + (ferr_n[0] - fa) + (ferr_n[1] - fb) + (ferr_n[2] - fc) !== 0) begin
      errors++; $display("FAIL rst_release_pulse: got %0d pulses want 0", (rcvd_n[0] - ra) + (rcvd_n[1] - rb) + (rcvd_n[2] - rc) + (ferr_n[0] - fa) + (ferr_n[1] - fb) + (ferr_n[2] - fc));
    end
    checks++;
    if (ifb.txbusy !== 1'b0 || ifb.txpin !== 1'b0) begin
      errors++; $display("FAIL rst_tx_aborted: got busy %b pin %b want 0 0", ifb.txbusy, ifb.txpin);
    end
    rb = rcvd_n[1];
    ifb.d    = 7'h6E;
    ifb.load = 1'b1;
    @(negedge clk);
    ifb.load = 1'b0;
    n = 0;
    while (rcvd_n[1] == rb && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 2000 || ifb.q !== 7'h6E) begin
      errors++; $display("FAIL rst_after_q: got %h after %0d clk want 6e", ifb.q, n);
    end
    checks++;
    if (ifb.parerr !== 1'b0 && ifb.bytercvd === 1'b1) begin
      errors++; $display("FAIL rst_after_par: got %b want 0", ifb.parerr);
    end
  endtask

  initial begin
    ifa.load = 1'b0; ifa.d = '0; ifa.rxpin = 1'b1;
    ifb.load = 1'b0; ifb.d = '0;
    ifc.load = 1'b0; ifc.d = '0; ifc.rxpin = 1'b1;
    test_reset();
    test_tx_frame();
    test_loopback();
    test_glitch();
    test_framing();
    test_parity();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_frame_ice40.md
# uart_frame_ice40

Parametrised successor to the fixed 8N1 UART core: a full-duplex asynchronous transmitter/receiver with configurable data width, parity mode, stop-bit count and oversampling rate. It adds parity and framing error reporting, break recovery and an asynchronous reset. It sits between the board-level baud prescaler (which supplies `bitxce`) and the byte-level host logic. Pin polarity matches the existing core, so it is a drop-in replacement where 8N1 without reset sufficed.

## Interface
- `DATABITS`, 8: data bits per frame, legal 5..9.
- `PARITY`, 0: 0 none, 1 even, 2 odd.
- `STOPBITS`, 1: transmitted stop bits, 1 or 2.
- `SUBDIV16`, 0: 0 gives 8 `bitxce` per bit, 1 gives 16.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `bitxce`  in  1  one-cycle strobe, 8 or 16 per bit period.
- `load`  in  1  transmit request; accepted only when `txbusy`=0.
- `d`  in  DATABITS  byte to transmit.
- `rxpin`  in  1  serial receive line, idle high.
- `txpin`  out  1  drives the INVERTED transmit pin; idle 0.
- `txbusy`  out  1  transmitter occupied.
- `bytercvd`  out  1  one-cycle pulse: frame received with a valid stop bit.
- `parerr`  out  1  one-cycle pulse coincident with `bytercvd` when the parity check fails; always 0 when PARITY=0.
- `frameerr`  out  1  one-cycle pulse when a stop bit is sampled low.
- `q`  out  DATABITS  last received data; updates only on `bytercvd`.

## Operation
- Reset: `txpin`, `txbusy`, `bytercvd`, `parerr`, `frameerr` = 0; `q` = 0; tx and rx dividers = 0; rx FSM = HUNT.
- Tx frame, in order (line levels, before inversion):
  - start bit 0;
  - data, LSB first;
  - parity bit if PARITY≠0, making the total ones count even or odd;
  - STOPBITS stop bits of 1.
- Tx divider: free-running, (8 or 16)-count, advanced by `bitxce`. Its wrap strobe, `txce`, shifts the frame.
- `load` with `txbusy`=0:
  - frame captured;
  - `txbusy`=1 the next cycle;
  - start bit appears on the line at the next `txce`.
- `load` with `txbusy`=1 is ignored; the frame in flight is unaltered.
- `txbusy` falls at the `txce` that ends the last stop bit.
- Rx FSM states:
  - HUNT: rx divider held at half period; `rxpin`=0 moves to START.
  - START: at mid-bit sample, `rxpin`=1 returns to HUNT (false start); otherwise DATA.
  - DATA: shift DATABITS samples, LSB first; then PARITY if PARITY≠0, else STOP.
  - PARITY: sample and compare.
  - STOP: mid-bit sample.
    - 1: `q` loads, `bytercvd` pulses (plus `parerr` if the parity check failed), then HUNT.
    - 0: `frameerr` pulses, `q` unchanged, go to BREAK.
  - BREAK: wait for `rxpin`=1, then HUNT. This prevents retriggering during a line break.
- The receiver checks only the first stop bit, regardless of STOPBITS.
- Tx and rx are independent; simultaneous events on both sides do not interact.

## Timing
- Mid-bit sample point: rx divider count (N/2) after the falling edge is detected, N = 8 or 16. Detection latency is 1 `clk`.
- Sample points then advance every N `bitxce`.
- `bytercvd`, `parerr` and `frameerr` assert on the `clk` after the stop-bit sample `bitxce`. Each is high exactly 1 cycle.
- `q` is valid from the `bytercvd` cycle until the next `bytercvd`.
- `load`→start bit latency: 1 to N `bitxce` periods, depending on tx divider phase.
- Frame length: 1 + DATABITS + (PARITY≠0) + STOPBITS bit periods.
- `rst` mid-frame:
  - immediately forces the outputs to their reset values;
  - the partial rx frame is discarded;
  - the tx frame is aborted with the line idle;
  - no pulse is generated on release.
- Back-to-back frames are received with no idle gap: HUNT is entered at the stop-bit midpoint, so the next start edge is caught.

## Structure
- Shared package `uart_pkg`:
  - rx state encodings HUNT, START, DATA, PARITY, STOP, BREAK;
  - parity mode constants NONE, EVEN, ODD.
- Sub-module `uart_frame_rx` holds the rx FSM, rx divider and shift register.
- Tx path and tx divider stay in the top level.
- Parameter legality is checked at elaboration time; illegal values are an elaboration error.

## Test plan
- DATABITS=8, PARITY=0, STOPBITS=1, SUBDIV16=0: `load` `d`=0xA5 -> inverted line shows start, bits 1,0,1,0,0,1,0,1, stop; `txbusy` high for exactly 10 bit periods after the first `txce`.
- Loopback, DATABITS=7, PARITY=1 (even), STOPBITS=2, SUBDIV16=1: send 0x55 -> one `bytercvd` pulse, `q`=0x55, `parerr`=0.
- Odd parity, inject a frame for 0x3C with the parity bit flipped -> `bytercvd` and `parerr` pulse in the same cycle, `q`=0x3C.
- Stop bit driven low, then line held low for 3 bit periods -> a single `frameerr` pulse, no `bytercvd`, `q` unchanged; the next valid frame after the line returns high is received correctly.
- Low glitch shorter than half a bit on `rxpin` -> FSM returns to HUNT, no output pulses; a `load` while `txbusy`=1 changes nothing on `txpin`.
- Assert `rst` mid-data-bit on both tx and rx -> all outputs 0 immediately; after release, the next complete frame round-trips correctly.
